// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear control, one byte-enabled write port and
// NUM_RD registered read ports. master drives requests, slave is the register file.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUMBER = 8,
    parameter int NUM_RD     = 2
);
    localparam int AW = $clog2(REG_NUMBER);
    localparam int BW = DATA_WIDTH / 8;

    logic                         clr;
    logic                         busy;
    logic                         en_w;
    logic [AW-1:0]                addr_w;
    logic [DATA_WIDTH-1:0]        data_w;
    logic [BW-1:0]                be_w;
    logic [NUM_RD-1:0]            en_r;
    logic [NUM_RD*AW-1:0]         addr_r;
    logic [NUM_RD*DATA_WIDTH-1:0] data_r;
    logic [NUM_RD-1:0]            valid_r;
    logic                         err_addr;

    modport master (
        output clr, en_w, addr_w, data_w, be_w, en_r, addr_r,
        input  busy, data_r, valid_r, err_addr
    );

    modport slave (
        input  clr, en_w, addr_w, data_w, be_w, en_r, addr_r,
        output busy, data_r, valid_r, err_addr
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enabled writes, optional
// write->read forwarding, a one-entry-per-cycle clear sweep and
// out-of-range address flagging. All outputs come straight from flops.
module reg_file_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUMBER = 8,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_mp_if.slave bus,
    output logic         state_dbg   // 0 = IDLE, 1 = CLEAR
);
    localparam int AW = $clog2(REG_NUMBER);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [AW:0]   REG_NUM_W = (AW+1)'(REG_NUMBER);
    localparam logic [AW-1:0] LAST_IDX  = AW'(REG_NUMBER - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [AW-1:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]        mem_q [REG_NUMBER];
    logic [DATA_WIDTH-1:0]        mem_d [REG_NUMBER];
    logic [NUM_RD*DATA_WIDTH-1:0] data_r_q, data_r_d;
    logic [NUM_RD-1:0]            valid_r_q, valid_r_d;
    logic                         err_q, err_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < REG_NUM_W;
    endfunction

    // Next state: sweep sequencing, writes, read capture and address errors.
    always_comb begin
        logic                  wr_ok;
        logic [AW-1:0]         ra;
        logic [DATA_WIDTH-1:0] word;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        data_r_d  = data_r_q;
        valid_r_d = '0;
        err_d     = 1'b0;
        wr_ok     = 1'b0;
        ra        = '0;
        word      = '0;
        case (state_q)
            IDLE: begin
                // A write landing in the same cycle as clr is dropped.
                wr_ok = bus.en_w && in_range(bus.addr_w) && !bus.clr;
                for (int p = 0; p < NUM_RD; p++) begin
                    if (bus.en_r[p]) begin
                        ra   = bus.addr_r[p*AW +: AW];
                        word = '0;
                        valid_r_d[p] = 1'b1;
                        if (in_range(ra)) begin
                            word = mem_q[ra];
                            if (BYPASS != 0 && wr_ok && bus.addr_w == ra) begin
                                for (int b = 0; b < BW; b++) begin
                                    if (bus.be_w[b]) word[8*b +: 8] = bus.data_w[8*b +: 8];
                                end
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                        data_r_d[p*DATA_WIDTH +: DATA_WIDTH] = word;
                    end
                end
                if (bus.en_w && !in_range(bus.addr_w)) err_d = 1'b1;
                if (wr_ok) begin
                    for (int b = 0; b < BW; b++) begin
                        if (bus.be_w[b]) mem_d[bus.addr_w][8*b +: 8] = bus.data_w[8*b +: 8];
                    end
                end
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears storage and aborts any sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < REG_NUMBER; i++) mem_q[i] <= '0;
            data_r_q  <= '0;
            valid_r_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
            data_r_q  <= data_r_d;
            valid_r_q <= valid_r_d;
            err_q     <= err_d;
        end
    end

    assign bus.busy     = (state_q == CLEAR);
    assign bus.data_r   = data_r_q;
    assign bus.valid_r  = valid_r_q;
    assign bus.err_addr = err_q;
    assign state_dbg    = logic'(state_q);
endmodule
